m58715_bus_responder: RTL and testbench

Bus-side counterpart to the M58715 sound MCU: answers its external program-fetch and MOVX cycles, and holds the main-CPU sound-command latch and interrupt. Decodes ALE/PSENn/RDn/WRn strobes and latches the multiplexed address. Serves opcodes from an external synchronous sound ROM, returns the command byte on MOVX reads, and publishes MOVX writes as one-cycle strobes. Sits between the MCU core's bus pins, the sound ROM and the main-CPU write decode.

---
 rtl/m58715_pkg.sv | 15 +
 rtl/m58715_strobe_sync.sv | 35 +++
 rtl/m58715_bus_responder.sv | 141 ++++++++++++++
 tb/tb_m58715_bus_responder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/m58715_pkg.sv
// m58715_pkg: shared types and constants for the M58715 bus responder
// Bus state enum, address widths, idle bus value and strobe vector layout.
package m58715_pkg;
    typedef enum logic [1:0] {IDLE, FETCH_WAIT, FETCH_HOLD, RD_HOLD} bus_state_t;
    localparam int ADDR_LO_W = 8;
    localparam int ADDR_W = 12;
    localparam logic [7:0] IDLE_DB_DEF = 8'hFF;
    // bit positions in the strobe vector {WRn, RDn, PSENn, ALE}
    localparam int STB_ALE = 0;
    localparam int STB_PSEN = 1;
    localparam int STB_RD = 2;
    localparam int STB_WR = 3;
    // idle history: ALE low, active-low strobes high
    localparam logic [3:0] STB_RST_VAL = 4'b1110;
endpackage

// File: rtl/m58715_strobe_sync.sv
// m58715_strobe_sync: registers the MCU bus strobes once and emits edge pulses
// Ports: i_clk/i_rst clock and sync reset; i_stb raw strobe pins;
//        o_lvl registered levels; o_fall/o_rise one-cycle edge pulses.
module m58715_strobe_sync
    import m58715_pkg::*;
#(
    parameter logic [3:0] RST_VAL = STB_RST_VAL
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_stb,
    output logic [3:0] o_lvl,
    output logic [3:0] o_fall,
    output logic [3:0] o_rise
);
    logic [3:0] r_cur;
    logic [3:0] r_prev;
    logic       r_first;
    // On the first clock after reset the history is seeded from the pins, so a
    // strobe already low at release never looks like a fresh falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cur   <= RST_VAL;
            r_prev  <= RST_VAL;
            r_first <= 1'b1;
        end else begin
            r_cur   <= i_stb;
            r_prev  <= r_first ? i_stb : r_cur;
            r_first <= 1'b0;
        end
    end
    assign o_lvl  = r_cur;
    assign o_fall = r_prev & ~r_cur;
    assign o_rise = ~r_prev & r_cur;
endmodule

// File: rtl/m58715_bus_responder.sv
// m58715_bus_responder: answers M58715 program fetches and MOVX cycles, holds the sound command latch
// Ports: I_CLK/I_RST clock and sync reset; I_ALE/I_PSENn/I_RDn/I_WRn MCU strobes;
//        I_DB/I_P2 multiplexed address/data in; O_DB data back to the MCU;
//        O_ROM_A/I_ROM_D sound ROM; I_CMD_WE/I_CMD_D main-CPU command write;
//        O_INTn MCU interrupt; O_WR_A/O_WR_D/O_WR_STB MOVX write publication.
module m58715_bus_responder
    import m58715_pkg::*;
#(
    parameter int         ROM_LAT = 1,
    parameter logic [7:0] IDLE_DB = IDLE_DB_DEF
) (
    input  logic                 I_CLK,
    input  logic                 I_RST,
    input  logic                 I_ALE,
    input  logic                 I_PSENn,
    input  logic                 I_RDn,
    input  logic                 I_WRn,
    input  logic [7:0]           I_DB,
    input  logic [3:0]           I_P2,
    output logic [7:0]           O_DB,
    output logic [ADDR_W-1:0]    O_ROM_A,
    input  logic [7:0]           I_ROM_D,
    input  logic                 I_CMD_WE,
    input  logic [7:0]           I_CMD_D,
    output logic                 O_INTn,
    output logic [ADDR_LO_W-1:0] O_WR_A,
    output logic [7:0]           O_WR_D,
    output logic                 O_WR_STB
);
    localparam logic [1:0] LAT = 2'(ROM_LAT);
    logic [3:0]        w_lvl;
    logic [3:0]        w_fall;
    logic [3:0]        w_rise;
    logic              w_wr_smp;
    logic              w_unused;
    logic [7:0]        r_db;
    logic [3:0]        r_p2;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wr_a;
    logic [7:0]        r_wr_d;
    logic [7:0]        r_odb;
    logic [7:0]        r_cmd;
    logic              r_pending;
    logic [1:0]        r_cnt;
    bus_state_t        r_state;

    m58715_strobe_sync u_sync (
        .i_clk  (I_CLK),
        .i_rst  (I_RST),
        .i_stb  ({I_WRn, I_RDn, I_PSENn, I_ALE}),
        .o_lvl  (w_lvl),
        .o_fall (w_fall),
        .o_rise (w_rise)
    );

    assign w_unused = ^{w_rise[2:0], w_fall[STB_WR], w_lvl[STB_ALE]};

    // Bus and P2 are registered alongside the strobes so the latch takes the
    // values present when ALE fell on the pin.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_db   <= '0;
            r_p2   <= '0;
            r_addr <= '0;
        end else begin
            r_db <= I_DB;
            r_p2 <= I_P2;
            if (w_fall[STB_ALE]) r_addr <= {r_p2, r_db};
        end
    end

    // Write data/address are captured on the clock that first samples WRn high,
    // so they are already valid during the strobe cycle that follows.
    assign w_wr_smp = I_WRn & ~w_lvl[STB_WR];

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_wr_a <= '0;
            r_wr_d <= '0;
        end else if (w_wr_smp) begin
            r_wr_a <= r_addr[ADDR_LO_W-1:0];
            r_wr_d <= I_DB;
        end
    end

    // The fetch branch is tested first so it wins over a simultaneous read;
    // the command write is applied last so its pending set beats a read clear.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_odb     <= IDLE_DB;
            r_cmd     <= '0;
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall[STB_PSEN]) begin
                        r_state <= FETCH_WAIT;
                        r_cnt   <= LAT;
                    end else if (w_fall[STB_RD]) begin
                        r_state   <= RD_HOLD;
                        r_odb     <= r_cmd;
                        r_pending <= 1'b0;
                    end
                end
                FETCH_WAIT: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_odb   <= I_ROM_D;
                        r_state <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (w_lvl[STB_PSEN]) begin
                        r_odb   <= IDLE_DB;
                        r_state <= IDLE;
                    end
                end
                RD_HOLD: begin
                    if (w_lvl[STB_RD]) begin
                        r_odb   <= IDLE_DB;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (I_CMD_WE) begin
                r_cmd     <= I_CMD_D;
                r_pending <= 1'b1;
            end
        end
    end

    assign O_DB     = r_odb;
    assign O_ROM_A  = r_addr;
    assign O_INTn   = ~r_pending;
    assign O_WR_A   = r_wr_a;
    assign O_WR_D   = r_wr_d;
    assign O_WR_STB = w_rise[STB_WR];
endmodule

// File: tb/tb_m58715_bus_responder.sv
// tb_m58715_bus_responder: directed bench for the M58715 bus responder (ROM_LAT 1 and 3)
module tb_m58715_bus_responder;
    logic        clk;
    logic        rst;
    logic        ale;
    logic        psen_n;
    logic        rd_n;
    logic        wr_n;
    logic [7:0]  db;
    logic [3:0]  p2;
    logic        cmd_we;
    logic [7:0]  cmd_d;
    logic [7:0]  rom_d;
    logic [7:0]  rom_d3;
    logic [7:0]  r3a;
    logic [7:0]  r3b;
    logic [7:0]  o_db;
    logic [7:0]  o_db3;
    logic [11:0] o_rom_a;
    logic [11:0] o_rom_a3;
    logic        o_intn;
    logic        o_intn3;
    logic [7:0]  o_wr_a;
    logic [7:0]  o_wr_a3;
    logic [7:0]  o_wr_d;
    logic [7:0]  o_wr_d3;
    logic        o_wr_stb;
    logic        o_wr_stb3;
    int          checks = 0;
    int          failures = 0;

    m58715_bus_responder #(.ROM_LAT(1)) dut (
        .I_CLK(clk), .I_RST(rst), .I_ALE(ale), .I_PSENn(psen_n), .I_RDn(rd_n), .I_WRn(wr_n),
        .I_DB(db), .I_P2(p2), .O_DB(o_db), .O_ROM_A(o_rom_a), .I_ROM_D(rom_d),
        .I_CMD_WE(cmd_we), .I_CMD_D(cmd_d), .O_INTn(o_intn),
        .O_WR_A(o_wr_a), .O_WR_D(o_wr_d), .O_WR_STB(o_wr_stb)
    );

    m58715_bus_responder #(.ROM_LAT(3)) dut3 (
        .I_CLK(clk), .I_RST(rst), .I_ALE(ale), .I_PSENn(psen_n), .I_RDn(rd_n), .I_WRn(wr_n),
        .I_DB(db), .I_P2(p2), .O_DB(o_db3), .O_ROM_A(o_rom_a3), .I_ROM_D(rom_d3),
        .I_CMD_WE(cmd_we), .I_CMD_D(cmd_d), .O_INTn(o_intn3),
        .O_WR_A(o_wr_a3), .O_WR_D(o_wr_d3), .O_WR_STB(o_wr_stb3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [11:0] a);
        return (a == 12'h234) ? 8'hA5 : (a[7:0] ^ 8'h5A);
    endfunction

    // synchronous ROM models: one and three cycles of latency
    always @(posedge clk) begin
        rom_d  <= rom_f(o_rom_a);
        r3a    <= rom_f(o_rom_a3);
        r3b    <= r3a;
        rom_d3 <= r3b;
    end

    task automatic nx(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; ale = 0; psen_n = 1; rd_n = 1; wr_n = 1;
        db = 0; p2 = 0; cmd_we = 0; cmd_d = 0;
        nx(3); rst = 0; nx(1);
        chk("rst_db", o_db, 8'hFF);
        chk("rst_db3", o_db3, 8'hFF);
        chk("rst_rom_a", o_rom_a, 12'h000);
        chk("rst_intn", o_intn, 1'b1);
        chk("rst_wr_a", o_wr_a, 8'h00);
        chk("rst_wr_d", o_wr_d, 8'h00);
        chk("rst_wr_stb", o_wr_stb, 1'b0);
        // fetch at 12'h234
        ale = 1; db = 8'h34; p2 = 4'h2; nx(1); ale = 0;
        nx(1); chk("ale_n1", o_rom_a, 12'h000);
        nx(1); chk("ale_n2", o_rom_a, 12'h234);
        nx(1); psen_n = 0;
        nx(2); chk("fetch_p2", o_db, 8'hFF);
        nx(1); chk("fetch_p3", o_db, 8'hA5); chk("fetch3_p3", o_db3, 8'hFF);
        nx(1); chk("fetch3_p4", o_db3, 8'hFF);
        nx(1); chk("fetch3_p5", o_db3, 8'hA5);
        nx(1); psen_n = 1;
        nx(1); chk("fetch_rel1", o_db, 8'hA5);
        nx(1); chk("fetch_rel2", o_db, 8'hFF); chk("fetch3_rel2", o_db3, 8'hFF);
        // command read
        nx(1); cmd_we = 1; cmd_d = 8'h5C; chk("intn_pre", o_intn, 1'b1);
        nx(1); cmd_we = 0; chk("intn_set", o_intn, 1'b0);
        nx(1); rd_n = 0;
        nx(1); chk("rd_d1", o_db, 8'hFF); chk("rd_intn1", o_intn, 1'b0);
        nx(1); chk("rd_d2", o_db, 8'h5C); chk("rd_intn2", o_intn, 1'b1); rd_n = 1;
        nx(1); chk("rd_hold", o_db, 8'h5C);
        nx(1); chk("rd_rel", o_db, 8'hFF);
        // command write colliding with a read edge
        nx(1); cmd_we = 1; cmd_d = 8'h22;
        nx(1); cmd_we = 0;
        nx(1); rd_n = 0;
        nx(1); cmd_we = 1; cmd_d = 8'h11;
        nx(1); cmd_we = 0; chk("coll_db", o_db, 8'h22); chk("coll_intn", o_intn, 1'b0); rd_n = 1;
        nx(2); chk("coll_rel", o_db, 8'hFF); chk("coll_intn2", o_intn, 1'b0);
        nx(1); rd_n = 0;
        nx(2); chk("coll_new", o_db, 8'h11); chk("coll_new_intn", o_intn, 1'b1); rd_n = 1;
        nx(2);
        // back-to-back command writes
        nx(1); cmd_we = 1; cmd_d = 8'h33;
        nx(1); cmd_d = 8'h44;
        nx(1); cmd_we = 0;
        nx(1); rd_n = 0;
        nx(2); chk("b2b_db", o_db, 8'h44); rd_n = 1;
        nx(2); chk("b2b_rel", o_db, 8'hFF);
        // MOVX write
        nx(1); ale = 1; db = 8'h80; p2 = 4'h0;
        nx(1); ale = 0;
        nx(3); chk("wr_rom_a", o_rom_a, 12'h080); wr_n = 0; db = 8'h7E;
        nx(2); wr_n = 1; chk("wr_stb_pre", o_wr_stb, 1'b0);
        nx(1); chk("wr_stb", o_wr_stb, 1'b1); chk("wr_a", o_wr_a, 8'h80); chk("wr_d", o_wr_d, 8'h7E);
        chk("wr_db_idle", o_db, 8'hFF);
        nx(1); chk("wr_stb_post", o_wr_stb, 1'b0); chk("wr_d_hold", o_wr_d, 8'h7E);
        // simultaneous PSENn/RDn with a command pending
        nx(1); cmd_we = 1; cmd_d = 8'h66;
        nx(1); cmd_we = 0;
        nx(1); psen_n = 0; rd_n = 0;
        nx(2); chk("sim_p2", o_db, 8'hFF);
        nx(1); chk("sim_p3", o_db, 8'hDA); chk("sim_intn", o_intn, 1'b0);
        nx(1); chk("sim3_p4", o_db3, 8'hFF);
        nx(1); chk("sim3_p5", o_db3, 8'hDA);
        nx(1); psen_n = 1; rd_n = 1;
        nx(2); chk("sim_rel", o_db, 8'hFF); chk("sim_intn_end", o_intn, 1'b0);
        // reset in FETCH_WAIT with PSENn held low through release
        nx(1); psen_n = 0;
        nx(2); rst = 1;
        nx(1); rst = 0;
        chk("mrst_db", o_db, 8'hFF); chk("mrst_intn", o_intn, 1'b1);
        chk("mrst_rom_a", o_rom_a, 12'h000); chk("mrst_wr_d", o_wr_d, 8'h00);
        chk("mrst_wr_a", o_wr_a, 8'h00);
        for (int i = 0; i < 6; i++) begin
            nx(1);
            chk("mrst_no_fetch", o_db, 8'hFF);
            chk("mrst_no_fetch3", o_db3, 8'hFF);
        end
        psen_n = 1;
        nx(2); psen_n = 0;
        nx(2); chk("refetch_p2", o_db, 8'hFF);
        nx(1); chk("refetch_p3", o_db, 8'h5A);
        nx(2); chk("refetch3_p5", o_db3, 8'h5A);
        psen_n = 1;
        nx(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
